// File: rtl/control_sequencer.sv
// Moore control-unit sequencer: fetch (T0,T1,[TW x MEM_WAIT],T2), then opcode-specific execute steps.
// Latency from T0: ALU/ldi 6, br 7, jr 4, nop/halt/illegal 3 (+MEM_WAIT); no backpressure, run sampled in IDLE only.
module control_sequencer #(
    parameter int BITS     = 32,
    parameter int MEM_WAIT = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [BITS-1:0] IR,
    input  logic            CON,
    output logic            PCout,
    output logic            MARin,
    output logic            IncPC,
    output logic            RZin,
    output logic            RZout,
    output logic            PCin,
    output logic            Read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            RYin,
    output logic            CONin,
    output logic            Cout,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            ADD,
    output logic            SUB,
    output logic            AND,
    output logic            OR,
    output logic            out,
    output logic [3:0]      state,
    output logic            instr_done,
    output logic            halted,
    output logic            illegal
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_TW = 4'd3, S_T2 = 4'd4,
        S_T3 = 4'd5, S_T4 = 4'd6, S_T5 = 4'd7, S_T6 = 4'd8, S_HALT = 4'd15
    } state_t;

    typedef struct packed {
        logic pc_out, mar_in, inc_pc, rz_in, rz_out, pc_in, read, mdr_in;
        logic mdr_out, ir_in, ry_in, con_in, c_out, gra, grb, grc;
        logic r_in, r_out, alu_add, alu_sub, alu_and, alu_or, out_en;
    } strb_t;

    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

    state_t     r_state, w_next;
    logic [4:0] r_opc, w_ir_op;
    logic [2:0] r_wait;
    logic       r_illegal;
    strb_t      w_stb;
    logic       w_done;
    logic       w_unused;

    function automatic logic is_exec(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
               (op == OP_LDI) || (op == OP_BR) || (op == OP_JR);
    endfunction

    function automatic logic is_known(input logic [4:0] op);
        return is_exec(op) || (op == OP_NOP) || (op == OP_HALT);
    endfunction

    assign w_ir_op  = IR[BITS-1 -: 5];
    assign w_unused = ^IR[BITS-6:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (run) w_next = S_T0;
            S_T0:   w_next = S_T1;
            S_T1:   w_next = (MEM_WAIT == 0) ? S_T2 : S_TW;
            S_TW:   if (r_wait <= 3'd1) w_next = S_T2;
            S_T2: begin
                if (is_exec(w_ir_op))        w_next = S_T3;
                else if (w_ir_op == OP_HALT) w_next = S_HALT;
                else                         w_next = S_T0;
            end
            S_T3:   w_next = (r_opc == OP_JR) ? S_T0 : S_T4;
            S_T4:   w_next = S_T5;
            S_T5:   w_next = (r_opc == OP_BR) ? S_T6 : S_T0;
            S_T6:   w_next = S_T0;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_opc     <= '0;
            r_wait    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T0)      r_wait <= WAIT_INIT;
            else if (r_state == S_TW) r_wait <= r_wait - 3'd1;
            // illegal stays up through the next fetch and drops as that fetch reaches T2
            if (r_state == S_T2) begin
                r_opc     <= w_ir_op;
                r_illegal <= !is_known(w_ir_op);
            end else if (w_next == S_T2) begin
                r_illegal <= 1'b0;
            end
        end
    end

    always_comb begin
        w_stb  = '0;
        w_done = 1'b0;
        case (r_state)
            S_T0: begin
                w_stb.pc_out = 1'b1; w_stb.mar_in = 1'b1; w_stb.inc_pc = 1'b1; w_stb.rz_in = 1'b1;
            end
            S_T1: begin
                w_stb.rz_out = 1'b1; w_stb.pc_in = 1'b1; w_stb.read = 1'b1; w_stb.mdr_in = 1'b1;
            end
            S_TW: begin
                w_stb.read = 1'b1; w_stb.mdr_in = 1'b1;
            end
            S_T2: begin
                w_stb.mdr_out = 1'b1; w_stb.ir_in = 1'b1;
                w_done = !is_exec(w_ir_op);
            end
            S_T3: begin
                w_stb.r_out = 1'b1;
                if (r_opc == OP_BR) begin
                    w_stb.gra = 1'b1; w_stb.con_in = 1'b1;
                end else if (r_opc == OP_JR) begin
                    w_stb.gra = 1'b1; w_stb.pc_in = 1'b1; w_done = 1'b1;
                end else begin
                    w_stb.grb = 1'b1; w_stb.ry_in = 1'b1;
                end
            end
            S_T4: begin
                if (r_opc == OP_BR) begin
                    w_stb.pc_out = 1'b1; w_stb.ry_in = 1'b1;
                end else if (r_opc == OP_LDI) begin
                    w_stb.c_out = 1'b1; w_stb.alu_add = 1'b1; w_stb.rz_in = 1'b1;
                end else begin
                    w_stb.grc = 1'b1; w_stb.r_out = 1'b1; w_stb.rz_in = 1'b1;
                    w_stb.alu_add = (r_opc == OP_ADD);
                    w_stb.alu_sub = (r_opc == OP_SUB);
                    w_stb.alu_and = (r_opc == OP_AND);
                    w_stb.alu_or  = (r_opc == OP_OR);
                end
            end
            S_T5: begin
                if (r_opc == OP_BR) begin
                    w_stb.c_out = 1'b1; w_stb.alu_add = 1'b1; w_stb.rz_in = 1'b1;
                end else begin
                    w_stb.rz_out = 1'b1; w_stb.gra = 1'b1; w_stb.r_in = 1'b1; w_done = 1'b1;
                end
            end
            S_T6: begin
                w_stb.rz_out = 1'b1; w_stb.pc_in = CON; w_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCout      = w_stb.pc_out;
    assign MARin      = w_stb.mar_in;
    assign IncPC      = w_stb.inc_pc;
    assign RZin       = w_stb.rz_in;
    assign RZout      = w_stb.rz_out;
    assign PCin       = w_stb.pc_in;
    assign Read       = w_stb.read;
    assign MDRin      = w_stb.mdr_in;
    assign MDRout     = w_stb.mdr_out;
    assign IRin       = w_stb.ir_in;
    assign RYin       = w_stb.ry_in;
    assign CONin      = w_stb.con_in;
    assign Cout       = w_stb.c_out;
    assign Gra        = w_stb.gra;
    assign Grb        = w_stb.grb;
    assign Grc        = w_stb.grc;
    assign Rin        = w_stb.r_in;
    assign Rout       = w_stb.r_out;
    assign ADD        = w_stb.alu_add;
    assign SUB        = w_stb.alu_sub;
    assign AND        = w_stb.alu_and;
    assign OR         = w_stb.alu_or;
    assign out        = w_stb.out_en;
    assign state      = r_state;
    assign instr_done = w_done;
    assign halted     = (r_state == S_HALT);
    assign illegal    = r_illegal;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (MEM_WAIT 0 and 3) checked every cycle against a
// per-instruction step schedule built from the opcode rules, plus hand-computed literal checks.
module tb_control_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v[2];
    logic        run_v[2];
    logic        con_v[2];
    logic [31:0] ir_v[2];

    wire [22:0] stb0, stb1;
    wire [3:0]  st0, st1;
    wire        dn0, dn1, hl0, hl1, il0, il1;

    control_sequencer #(.BITS(32), .MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(rst_v[0]), .run(run_v[0]), .IR(ir_v[0]), .CON(con_v[0]),
        .PCout(stb0[22]), .MARin(stb0[21]), .IncPC(stb0[20]), .RZin(stb0[19]), .RZout(stb0[18]),
        .PCin(stb0[17]), .Read(stb0[16]), .MDRin(stb0[15]), .MDRout(stb0[14]), .IRin(stb0[13]),
        .RYin(stb0[12]), .CONin(stb0[11]), .Cout(stb0[10]), .Gra(stb0[9]), .Grb(stb0[8]),
        .Grc(stb0[7]), .Rin(stb0[6]), .Rout(stb0[5]), .ADD(stb0[4]), .SUB(stb0[3]),
        .AND(stb0[2]), .OR(stb0[1]), .out(stb0[0]),
        .state(st0), .instr_done(dn0), .halted(hl0), .illegal(il0)
    );

    control_sequencer #(.BITS(32), .MEM_WAIT(3)) dut1 (
        .clk(clk), .reset(rst_v[1]), .run(run_v[1]), .IR(ir_v[1]), .CON(con_v[1]),
        .PCout(stb1[22]), .MARin(stb1[21]), .IncPC(stb1[20]), .RZin(stb1[19]), .RZout(stb1[18]),
        .PCin(stb1[17]), .Read(stb1[16]), .MDRin(stb1[15]), .MDRout(stb1[14]), .IRin(stb1[13]),
        .RYin(stb1[12]), .CONin(stb1[11]), .Cout(stb1[10]), .Gra(stb1[9]), .Grb(stb1[8]),
        .Grc(stb1[7]), .Rin(stb1[6]), .Rout(stb1[5]), .ADD(stb1[4]), .SUB(stb1[3]),
        .AND(stb1[2]), .OR(stb1[1]), .out(stb1[0]),
        .state(st1), .instr_done(dn1), .halted(hl1), .illegal(il1)
    );

    localparam logic [22:0] M_PCOUT  = 23'd1 << 22;
    localparam logic [22:0] M_MARIN  = 23'd1 << 21;
    localparam logic [22:0] M_INCPC  = 23'd1 << 20;
    localparam logic [22:0] M_RZIN   = 23'd1 << 19;
    localparam logic [22:0] M_RZOUT  = 23'd1 << 18;
    localparam logic [22:0] M_PCIN   = 23'd1 << 17;
    localparam logic [22:0] M_READ   = 23'd1 << 16;
    localparam logic [22:0] M_MDRIN  = 23'd1 << 15;
    localparam logic [22:0] M_MDROUT = 23'd1 << 14;
    localparam logic [22:0] M_IRIN   = 23'd1 << 13;
    localparam logic [22:0] M_RYIN   = 23'd1 << 12;
    localparam logic [22:0] M_CONIN  = 23'd1 << 11;
    localparam logic [22:0] M_COUT   = 23'd1 << 10;
    localparam logic [22:0] M_GRA    = 23'd1 << 9;
    localparam logic [22:0] M_GRB    = 23'd1 << 8;
    localparam logic [22:0] M_GRC    = 23'd1 << 7;
    localparam logic [22:0] M_RIN    = 23'd1 << 6;
    localparam logic [22:0] M_ROUT   = 23'd1 << 5;
    localparam logic [22:0] M_ADD    = 23'd1 << 4;
    localparam logic [29:0] W_HALT   = {4'hF, 1'b0, 1'b1, 1'b0, 23'd0};

    // word layout: {state[3:0], instr_done, halted, illegal, strobes[22:0]}
    logic [29:0] q0[$], q1[$];
    logic [29:0] steady[2];
    logic        ill_prev[2];
    int tests = 0;
    int fails = 0;
    int o_states, o_read, o_pcin, o_add, o_gra, o_done;

    function automatic logic [29:0] act_word(input int d);
        return (d == 0) ? {st0, dn0, hl0, il0, stb0} : {st1, dn1, hl1, il1, stb1};
    endfunction

    function automatic void push(input int d, input int st, input logic [22:0] s, input logic dn, input logic ill);
        logic [29:0] w;
        w = {4'(st), dn, 1'b0, ill, s};
        if (d == 0) q0.push_back(w);
        else        q1.push_back(w);
    endfunction

    // Expected step schedule of one instruction; returns its length in cycles.
    function automatic int gen(input int d, input logic [4:0] op, input logic con);
        int   mw    = (d == 0) ? 0 : 3;
        logic ip    = ill_prev[d];
        bit   alu   = (op >= 5'd3) && (op <= 5'd6);
        bit   ldi   = (op == 5'd1);
        bit   br    = (op == 5'd18);
        bit   jr    = (op == 5'd20);
        bit   known = alu || ldi || br || jr || (op == 5'd26) || (op == 5'd27);
        bit   short = !(alu || ldi || br || jr);
        int   n     = 3 + mw;
        push(d, 1, M_PCOUT | M_MARIN | M_INCPC | M_RZIN, 1'b0, ip);
        push(d, 2, M_RZOUT | M_PCIN | M_READ | M_MDRIN, 1'b0, ip);
        for (int k = 0; k < mw; k++) push(d, 3, M_READ | M_MDRIN, 1'b0, ip);
        push(d, 4, M_MDROUT | M_IRIN, short, 1'b0);
        if (alu || ldi) begin
            push(d, 5, M_GRB | M_ROUT | M_RYIN, 1'b0, 1'b0);
            if (alu) push(d, 6, M_GRC | M_ROUT | M_RZIN | (M_ADD >> (int'(op) - 3)), 1'b0, 1'b0);
            else     push(d, 6, M_COUT | M_ADD | M_RZIN, 1'b0, 1'b0);
            push(d, 7, M_RZOUT | M_GRA | M_RIN, 1'b1, 1'b0);
            n += 3;
        end else if (br) begin
            push(d, 5, M_GRA | M_ROUT | M_CONIN, 1'b0, 1'b0);
            push(d, 6, M_PCOUT | M_RYIN, 1'b0, 1'b0);
            push(d, 7, M_COUT | M_ADD | M_RZIN, 1'b0, 1'b0);
            push(d, 8, M_RZOUT | (con ? M_PCIN : 23'd0), 1'b1, 1'b0);
            n += 4;
        end else if (jr) begin
            push(d, 5, M_GRA | M_ROUT | M_PCIN, 1'b1, 1'b0);
            n += 1;
        end
        ill_prev[d] = !known;
        if (op == 5'd27) steady[d] = W_HALT;
        return n;
    endfunction

    always @(negedge clk) begin : compare
        logic [29:0] a, e;
        for (int d = 0; d < 2; d++) begin
            a = act_word(d);
            e = steady[d];
            if (d == 0 && q0.size() > 0) e = q0.pop_front();
            if (d == 1 && q1.size() > 0) e = q1.pop_front();
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle dut%0d t=%0t: got st=%0d done=%0b halted=%0b ill=%0b stb=%06h, want st=%0d done=%0b halted=%0b ill=%0b stb=%06h",
                         d, $time, a[29:26], a[25], a[24], a[23], a[22:0], e[29:26], e[25], e[24], e[23], e[22:0]);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic start(input int d);
        run_v[d] = 1'b1;
        @(posedge clk); #1;
        run_v[d] = 1'b0;
    endtask

    // Called #1 after the edge that entered T0; returns #1 after the edge that leaves the instruction.
    task automatic exec(input int d, input logic [31:0] ir, input logic con, input int abort_at);
        int n;
        logic [29:0] w;
        ir_v[d]  = ir;
        con_v[d] = con;
        n = gen(d, ir[31:27], con);
        o_states = 0; o_read = 0; o_pcin = 0; o_add = 0; o_gra = 0; o_done = 0;
        for (int i = 1; i <= n; i++) begin
            w = act_word(d);
            if (i == abort_at) begin
                check("pre_reset_busy", int'(w[22:0] != 23'd0), 1);
                rst_v[d] = 1'b0;
                if (d == 0) q0.delete();
                else        q1.delete();
                steady[d] = '0;
                ill_prev[d] = 1'b0;
                #1;
                check("reset_async_clear", int'(act_word(d)), 0);
                @(posedge clk); #1;
                rst_v[d] = 1'b1;
                return;
            end
            o_states = (o_states << 4) | int'(w[29:26]);
            if (w[16]) o_read |= 1 << (i - 1);
            if (w[17]) o_pcin |= 1 << (i - 1);
            if (w[4])  o_add  |= 1 << (i - 1);
            if (w[9])  o_gra  |= 1 << (i - 1);
            if (w[25]) o_done |= 1 << (i - 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin : stim
        int nz;
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b0; run_v[d] = 1'b0; con_v[d] = 1'b0; ir_v[d] = '0;
            steady[d] = '0; ill_prev[d] = 1'b0;
        end
        #2;
        check("reset_state", int'(st0), 0);
        check("reset_halted", int'(hl0), 0);
        check("reset_strobes", int'(stb1), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_v[0] = 1'b1; rst_v[1] = 1'b1;
        @(posedge clk); #1;
        check("idle_without_run", int'(st0), 0);

        start(0);
        exec(0, 32'h1800_0000, 1'b0, 0);
        check("add_states", o_states, 'h124567);
        check("add_then_t0", int'(st0), 1);
        check("add_strobe_cycle", o_add, 'h10);
        check("add_done_cycle", o_done, 'h20);
        exec(0, 32'h2000_0000, 1'b0, 0);
        exec(0, 32'h9000_0000, 1'b1, 0);
        check("br_con1_pcin", o_pcin, 'h42);
        check("br_con1_done", o_done, 'h40);
        exec(0, 32'h9000_0000, 1'b0, 0);
        check("br_con0_pcin", o_pcin, 'h02);
        check("br_con0_done", o_done, 'h40);
        exec(0, 32'hA000_0000, 1'b0, 0);
        check("jr_pcin", o_pcin, 'h0A);
        check("jr_gra", o_gra, 'h08);
        check("jr_done", o_done, 'h08);
        exec(0, 32'hF800_0000, 1'b0, 0);
        check("illegal_states", o_states, 'h124);
        check("illegal_done", o_done, 'h04);
        check("illegal_flag", int'(il0), 1);
        exec(0, 32'hD000_0000, 1'b0, 0);
        check("nop_clears_illegal", int'(il0), 0);
        exec(0, 32'h1800_0000, 1'b0, 5);
        repeat (5) @(posedge clk);
        #1;
        check("idle_after_t4_reset", int'(st0), 0);

        start(1);
        exec(1, 32'h0800_0000, 1'b0, 0);
        check("ldi_read_cycles", o_read, 'h1E);
        check("ldi_done", o_done, 'h100);
        exec(1, 32'h3000_0000, 1'b0, 0);
        exec(1, 32'h1800_0000, 1'b0, 3);
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_tw_reset", int'(st1), 0);
        start(1);
        exec(1, 32'h2800_0000, 1'b0, 0);
        exec(1, 32'hD800_0000, 1'b0, 0);
        check("halt_done", o_done, 'h20);
        check("halt_state", int'(st1), 15);
        check("halt_flag", int'(hl1), 1);
        run_v[1] = 1'b1;
        nz = 0;
        repeat (20) begin
            if (stb1 != 23'd0 || dn1) nz++;
            @(posedge clk); #1;
        end
        check("halt_quiet", nz, 0);
        check("halt_hold", int'(st1), 15);
        rst_v[1] = 1'b0; run_v[1] = 1'b0;
        steady[1] = '0; ill_prev[1] = 1'b0;
        #1;
        check("halt_reset_state", int'(st1), 0);
        check("halt_reset_flag", int'(hl1), 0);
        @(posedge clk); #1;
        rst_v[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_halt_reset", int'(st1), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
